forth_io_bridge: RTL
====================

FORTH_IO_BRIDGE -- requirements
Module: forth_io_bridge

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, data/address width; RAM_BITS, default 10, RAM address bits; RAM_WAIT, default 1, extra wait cycles per RAM access (0..15).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_address  in  WIDTH  CPU address.
- mem_data_in  in  WIDTH  CPU write data.
- mem_data_out  out  WIDTH  read data to CPU.
- mem_valid  in  1  CPU request.
- mem_nwr  in  1  0 = write, 1 = read.
- mem_ready  out  1  access complete.
- interrupt  out  2  [1] = external pending, [0] = timer pending.
- interrupt_ack  in  2  CPU in-service code: 0 = none, 1 = timer, 2 = external.
- ext_irq  in  1  asynchronous external interrupt line.
- gpio_out  out  8  general-purpose output register.

Function
REQ-003 SHALL use this address map:
- 0 .. 2^RAM_BITS-1: RAM, WIDTH-bit words.
- 0xFF00: LOAD (r/w).
- 0xFF01: COUNT (read-only).
- 0xFF02: CTRL[2:0] (r/w): bit0 enable, bit1 auto-reload, bit2 irq-enable.
- 0xFF03: STATUS[1:0]: bit0 timer pending, bit1 external pending; write-1-to-clear.
- 0xFF04: GPIO[7:0] (r/w).
- Any other address: reads 0, writes ignored, still completes.
REQ-004 Bus FSM states SHALL be IDLE, WAIT, ACK, DONE.
REQ-005 IDLE with mem_valid=1 SHALL capture address, data and direction.
- RAM access with RAM_WAIT>0: go to WAIT and load the wait counter with RAM_WAIT.
- Otherwise: go directly to ACK.
REQ-006 WAIT SHALL decrement the counter each cycle and go to ACK when it reaches 0.
REQ-007 Entering ACK SHALL:
- perform the write, or drive read data on mem_data_out;
- set mem_ready=1 for exactly one cycle;
- then go to DONE.
REQ-008 DONE SHALL return to IDLE once mem_valid=0. A mem_valid still high in DONE SHALL NOT start a new access.
REQ-009 mem_data_out SHALL hold the last read value until the next read completes.
REQ-010 Latency from valid sampled to mem_ready high SHALL be 1 cycle for registers and 1+RAM_WAIT cycles for RAM.
REQ-011 Timer behaviour:
- Writing LOAD SHALL also copy the value into COUNT.
- While enable=1, COUNT SHALL decrement by 1 per clk.
- When COUNT==0 and enable=1, then on that cycle:
  - if irq-enable=1, timer pending SHALL be set;
  - if auto-reload=1, COUNT SHALL be reloaded from LOAD;
  - otherwise, enable SHALL be cleared.
- COUNT SHALL never wrap below 0.
REQ-012 ext_irq SHALL pass through a 2-flop synchronizer. A synchronized 0->1 edge SHALL set external pending.
REQ-013 interrupt SHALL equal {external pending, timer pending}, registered.
REQ-014 On an interrupt_ack transition from 0 to nonzero:
- value 1 SHALL clear timer pending;
- value 2 SHALL clear external pending;
- value 3 SHALL clear both.
REQ-015 A set event SHALL win over a simultaneous clear (ack edge or STATUS write) in the same cycle.
REQ-016 A CPU write to CTRL while the timer expires SHALL take precedence for the enable bit. The expiry's pending set SHALL still occur.

Reset
REQ-017 Reset SHALL asynchronously force all of the following to 0:
- outputs: mem_ready, mem_data_out, interrupt, gpio_out;
- registers: LOAD, COUNT, CTRL, STATUS, synchronizer flops, previous-ack register;
- FSM SHALL go to IDLE.
RAM contents SHALL be left unchanged.
REQ-018 Reset asserted mid-access SHALL abort the access. No RAM write SHALL occur if reset is asserted before the ACK cycle.

Verification
REQ-019 RAM_WAIT=1, write 0x1234 to 0x0005, then read 0x0005 -> mem_ready is high on the 2nd cycle after valid each time; read returns 0x1234.
REQ-020 Write LOAD=3, CTRL=0x7 -> COUNT goes 3,2,1,0; interrupt=01 at expiry; COUNT reloads to 3; a second expiry 4 cycles later keeps interrupt=01.
REQ-021 ext_irq rising edge -> interrupt[1]=1 exactly 3 cycles later; interrupt_ack 0->2 clears it the following cycle; holding ack at 2 does not re-clear a new edge.
REQ-022 Timer expiry on the same cycle that ack=1 rises -> timer pending remains 1.
REQ-023 Read 0xFF10 -> mem_data_out=0 with a 1-cycle ready; write 0xFF04=0xA5 -> gpio_out=0xA5; STATUS write 0x3 -> interrupt=00.
REQ-024 Reset asserted during WAIT of a RAM write -> mem_ready=0 immediately, RAM word unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/forth_io_bridge.sv
// CPU memory-bus bridge: word RAM, down-counting timer with reload, external
// interrupt input and an 8-bit GPIO register behind a four-state handshake.
module forth_io_bridge #(
  parameter int WIDTH    = 16,
  parameter int RAM_BITS = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] mem_data_out,
  input  logic             mem_valid,
  input  logic             mem_nwr,
  output logic             mem_ready,
  output logic [1:0]       interrupt,
  input  logic [1:0]       interrupt_ack,
  input  logic             ext_irq,
  output logic [7:0]       gpio_out
);

  localparam logic [WIDTH-1:0] ADDR_LOAD   = WIDTH'(16'hFF00);
  localparam logic [WIDTH-1:0] ADDR_COUNT  = WIDTH'(16'hFF01);
  localparam logic [WIDTH-1:0] ADDR_CTRL   = WIDTH'(16'hFF02);
  localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(16'hFF03);
  localparam logic [WIDTH-1:0] ADDR_GPIO   = WIDTH'(16'hFF04);
  localparam logic [3:0]       WAIT_CYCLES = 4'(RAM_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             nwr_q, nwr_d;
  logic             mem_ready_q, mem_ready_d;
  logic [WIDTH-1:0] mem_data_out_q, mem_data_out_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             tmr_pend_q, tmr_pend_d;
  logic             ext_pend_q, ext_pend_d;
  logic [7:0]       gpio_q, gpio_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic [1:0]       ack_prev_q;

  logic [WIDTH-1:0] ram [0:(1 << RAM_BITS)-1];

  logic                in_is_ram, acc_is_ram, acc_nwr;
  logic [WIDTH-1:0]    acc_addr, acc_wdata, rd_val;
  logic [RAM_BITS-1:0] acc_idx;
  logic                enter_ack, bus_wr, bus_rd, ram_we;
  logic                wr_load, wr_ctrl, wr_status, wr_gpio;
  logic                expire, tmr_set, tmr_clr, ext_set, ext_clr, ack_edge;

  assign in_is_ram = (mem_address >> RAM_BITS) == '0;

  // Bus FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_valid) state_d = (in_is_ram && RAM_WAIT > 0) ? WAIT : ACK;
      WAIT: if (wait_cnt_q <= 4'd1) state_d = ACK;
      ACK:  state_d = DONE;
      DONE: if (!mem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and wait counter
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nwr_d      = nwr_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE && mem_valid) begin
      addr_d     = mem_address;
      wdata_d    = mem_data_in;
      nwr_d      = mem_nwr;
      wait_cnt_d = WAIT_CYCLES;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end
  end

  // Bus FSM: outputs. A register access enters ACK straight from IDLE, so the
  // live request is used there; otherwise the captured copy is.
  always_comb begin
    acc_addr   = (state_q == IDLE) ? mem_address : addr_q;
    acc_wdata  = (state_q == IDLE) ? mem_data_in : wdata_q;
    acc_nwr    = (state_q == IDLE) ? mem_nwr     : nwr_q;
    acc_is_ram = (acc_addr >> RAM_BITS) == '0;
    acc_idx    = acc_addr[RAM_BITS-1:0];
    enter_ack  = (state_d == ACK);
    bus_wr     = enter_ack && !acc_nwr;
    bus_rd     = enter_ack && acc_nwr;
    ram_we     = bus_wr && acc_is_ram && !reset;
    wr_load    = bus_wr && (acc_addr == ADDR_LOAD);
    wr_ctrl    = bus_wr && (acc_addr == ADDR_CTRL);
    wr_status  = bus_wr && (acc_addr == ADDR_STATUS);
    wr_gpio    = bus_wr && (acc_addr == ADDR_GPIO);
    rd_val     = '0;
    if (acc_is_ram) begin
      rd_val = ram[acc_idx];
    end else begin
      case (acc_addr)
        ADDR_LOAD:   rd_val = load_q;
        ADDR_COUNT:  rd_val = count_q;
        ADDR_CTRL:   rd_val = WIDTH'(ctrl_q);
        ADDR_STATUS: rd_val = WIDTH'({ext_pend_q, tmr_pend_q});
        ADDR_GPIO:   rd_val = WIDTH'(gpio_q);
        default:     rd_val = '0;
      endcase
    end
    mem_ready_d    = enter_ack;
    mem_data_out_d = bus_rd ? rd_val : mem_data_out_q;
  end

  // Timer; a CPU write to LOAD or CTRL overrides the counter's own update
  always_comb begin
    expire  = ctrl_q[0] && (count_q == '0);
    tmr_set = expire && ctrl_q[2];
    load_d  = wr_load ? acc_wdata : load_q;
    count_d = count_q;
    if (ctrl_q[0]) count_d = (count_q == '0) ? (ctrl_q[1] ? load_q : count_q) : count_q - 1'b1;
    if (wr_load) count_d = acc_wdata;
    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    if (wr_ctrl) ctrl_d = acc_wdata[2:0];
    gpio_d = wr_gpio ? acc_wdata[7:0] : gpio_q;
  end

  // Pending flags: set beats clear in the same cycle
  always_comb begin
    ack_edge   = (ack_prev_q == 2'd0) && (interrupt_ack != 2'd0);
    ext_set    = sync2_q && !sync3_q;
    tmr_clr    = (ack_edge && interrupt_ack[0]) || (wr_status && acc_wdata[0]);
    ext_clr    = (ack_edge && interrupt_ack[1]) || (wr_status && acc_wdata[1]);
    tmr_pend_d = tmr_set || (tmr_pend_q && !tmr_clr);
    ext_pend_d = ext_set || (ext_pend_q && !ext_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      nwr_q          <= 1'b0;
      mem_ready_q    <= 1'b0;
      mem_data_out_q <= '0;
      load_q         <= '0;
      count_q        <= '0;
      ctrl_q         <= '0;
      tmr_pend_q     <= 1'b0;
      ext_pend_q     <= 1'b0;
      gpio_q         <= '0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      ack_prev_q     <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      nwr_q          <= nwr_d;
      mem_ready_q    <= mem_ready_d;
      mem_data_out_q <= mem_data_out_d;
      load_q         <= load_d;
      count_q        <= count_d;
      ctrl_q         <= ctrl_d;
      tmr_pend_q     <= tmr_pend_d;
      ext_pend_q     <= ext_pend_d;
      gpio_q         <= gpio_d;
      sync1_q        <= ext_irq;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
      ack_prev_q     <= interrupt_ack;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[acc_idx] <= acc_wdata;
  end

  assign mem_ready    = mem_ready_q;
  assign mem_data_out = mem_data_out_q;
  assign interrupt    = {ext_pend_q, tmr_pend_q};
  assign gpio_out     = gpio_q;

endmodule
